apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
- N-to-1 round-robin APB arbiter that lets several APB masters share one APB slave segment.
- Example use: the AXI-to-APB bridge plus a boot/debug config master both reaching the peripheral bus splitter.
- Each granted master request is replayed as a clean SETUP/ACCESS transfer on the slave side. Losers are stalled via pready.
- A programmable watchdog terminates hung slave transfers with an error.

Parameters:
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- NUM_MASTERS, 2, number of requesting masters (legal 2..8)
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before forced error; 0 disables watchdog (max 65535)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- m_paddr_i  in  NUM_MASTERS*APB_ADDR_WIDTH  master addresses, master i at slice i
- m_pwdata_i  in  NUM_MASTERS*APB_DATA_WIDTH  master write data
- m_pwrite_i  in  NUM_MASTERS  master write flags
- m_psel_i  in  NUM_MASTERS  master selects (request)
- m_penable_i  in  NUM_MASTERS  master enables (ignored for arbitration)
- m_prdata_o  out  NUM_MASTERS*APB_DATA_WIDTH  read data per master
- m_pready_o  out  NUM_MASTERS  completion per master
- m_pslverr_o  out  NUM_MASTERS  error per master
- s_paddr_o  out  APB_ADDR_WIDTH  slave address
- s_pwdata_o  out  APB_DATA_WIDTH  slave write data
- s_pwrite_o  out  1  slave write flag
- s_psel_o  out  1  slave select
- s_penable_o  out  1  slave enable
- s_prdata_i  in  APB_DATA_WIDTH  slave read data
- s_pready_i  in  1  slave ready
- s_pslverr_i  in  1  slave error
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; grant_o = 0.
  - All s_* outputs = 0; all m_pready_o, m_pslverr_o, m_prdata_o = 0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 wins first.
  - Watchdog counter = 0; timeout_o = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Requesters are masters with m_psel_i[i]=1.
  - Winner is the first requester searching from (ptr+1) mod N upward, with wrap-around.
  - At the clock edge: capture the winner's paddr/pwdata/pwrite into the s_* registers, set grant_o one-hot, set ptr=winner, go to SETUP.
  - No requester: stay in IDLE.
- SETUP: s_psel_o=1, s_penable_o=0, counter cleared; next state ACCESS (always one cycle).
- ACCESS: s_psel_o=1, s_penable_o=1.
  - If s_pready_i=1 in a cycle: combinationally drive m_pready_o[g]=1, m_prdata_o[g]=s_prdata_i, m_pslverr_o[g]=s_pslverr_i. Next state IDLE, grant_o cleared, s_psel_o/s_penable_o low.
  - Else increment the counter (saturating 16-bit).
  - Watchdog abort: TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 with s_pready_i=0. Then drive m_pready_o[g]=1, m_pslverr_o[g]=1, m_prdata_o[g]=0, pulse timeout_o, go to IDLE. A late pready from the slave is ignored.
- Non-granted masters: m_pready_o, m_pslverr_o and m_prdata_o stay 0. The master stays stalled in its own ACCESS phase, which is APB-legal.
- Slave outputs are registered and hold stable from SETUP through ACCESS. s_paddr_o, s_pwdata_o and s_pwrite_o hold their last value while IDLE.
- Latency: a request seen in IDLE at cycle 0 gives SETUP in cycle 1 and ACCESS in cycle 2. With a zero-wait slave, the master completes in cycle 2 (3 cycles minimum).
- Back-to-back: after completion the FSM always passes through IDLE for one cycle. The same master re-requesting competes normally, so with continuous requests from all masters, grants rotate strictly.
- Simultaneous requests: resolved only by the pointer order; no master gets two grants while another requests.
- Master drops m_psel_i while granted: protocol violation. The arbiter still completes the captured transfer and the response is discarded.
- Reset mid-transfer: everything returns to reset values immediately, s_psel_o drops asynchronously, and the pointer resets.

Test Plan:
- Single master 0 read of 0x1A10_0008, slave zero-wait returns 0xDEAD_BEEF -> s_psel_o high in cycles 1–2, m_pready_o[0] in cycle 2 with m_prdata_o[0]=0xDEAD_BEEF, grant_o 01 then 00.
- Masters 0 and 1 both request in the same cycle after reset -> master 0 served first, then master 1. Slave sees two distinct SETUP/ACCESS pairs with each master's address/wdata (writes 0x11, 0x22). m_pready_o[1] stays 0 until its own completion.
- Both masters requesting continuously for 6 transfers -> grant sequence 0,1,0,1,0,1; s_paddr_o alternates accordingly.
- Slave inserts 3 wait states with s_pslverr_i=1 on completion -> master sees pready only on the 4th ACCESS cycle with pslverr=1; s_paddr_o/s_pwdata_o stable throughout.
- TIMEOUT_CYCLES=8, slave never asserts pready -> after 8 ACCESS cycles m_pready_o=1, m_pslverr_o=1, m_prdata_o=0, timeout_o one-cycle pulse, FSM back to IDLE; the next requester is served normally.
- rst_ni asserted during ACCESS of master 1 -> s_psel_o/s_penable_o/grant_o go 0 immediately. After release, with both requesting, master 0 is granted first.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// N-to-1 round-robin APB arbiter with a slave-side watchdog.
// The winner's request is replayed as a SETUP/ACCESS pair on the slave bus.
module apb_rr_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr_i,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] m_pwdata_i,
  input  logic [NUM_MASTERS-1:0]               m_pwrite_i,
  input  logic [NUM_MASTERS-1:0]               m_psel_i,
  input  logic [NUM_MASTERS-1:0]               m_penable_i,
  output logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] m_prdata_o,
  output logic [NUM_MASTERS-1:0]               m_pready_o,
  output logic [NUM_MASTERS-1:0]               m_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]            s_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]            s_pwdata_o,
  output logic                                 s_pwrite_o,
  output logic                                 s_psel_o,
  output logic                                 s_penable_o,
  input  logic [APB_DATA_WIDTH-1:0]            s_prdata_i,
  input  logic                                 s_pready_i,
  input  logic                                 s_pslverr_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 timeout_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST =
    WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_MASTERS - 1);

  logic [1:0]             state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          win;
  logic [PW-1:0]          idx;
  logic                   found;
  logic [15:0]            cnt;
  logic [NUM_MASTERS-1:0] grant;
  logic                   wd_abort;
  logic                   unused_penable;

  assign unused_penable = ^m_penable_i;

  assign grant_o     = grant;
  assign s_psel_o    = (state != IDLE);
  assign s_penable_o = (state == ACCESS);

  // Watchdog fires on the last allowed ACCESS cycle without pready
  assign wd_abort = WD_EN && (state == ACCESS)
                 && !s_pready_i && (cnt == TO_LAST);
  assign timeout_o = wd_abort;

  // Pick the first requester after the last owner, wrapping around
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_MASTERS);
      if (!found && m_psel_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Route the slave response (or a forced error) to the owner only
  always_comb begin
    m_pready_o  = '0;
    m_pslverr_o = '0;
    m_prdata_o  = '0;
    if (state == ACCESS) begin
      if (s_pready_i) begin
        m_pready_o[ptr]  = 1'b1;
        m_pslverr_o[ptr] = s_pslverr_i;
        m_prdata_o[ptr*APB_DATA_WIDTH +: APB_DATA_WIDTH] = s_prdata_i;
      end else if (wd_abort) begin
        m_pready_o[ptr]  = 1'b1;
        m_pslverr_o[ptr] = 1'b1;
      end
    end
  end

  // Transfer FSM, request capture, pointer and watchdog counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= PTR_RST;
      cnt        <= '0;
      s_paddr_o  <= '0;
      s_pwdata_o <= '0;
      s_pwrite_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            s_paddr_o  <= m_paddr_i[win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            s_pwdata_o <= m_pwdata_i[win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            s_pwrite_o <= m_pwrite_i[win];
            grant      <= NUM_MASTERS'(1) << win;
            ptr        <= win;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (s_pready_i || wd_abort) begin
            state <= IDLE;
            grant <= '0;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter against a transaction-level
// round-robin model with a scripted slave.
module tb_apb_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int TO = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NM*AW-1:0]  m_paddr_i = '0;
  logic [NM*DW-1:0]  m_pwdata_i = '0;
  logic [NM-1:0]     m_pwrite_i = '0;
  logic [NM-1:0]     m_psel_i = '0;
  logic [NM-1:0]     m_penable_i = '0;
  logic [NM*DW-1:0]  m_prdata_o;
  logic [NM-1:0]     m_pready_o;
  logic [NM-1:0]     m_pslverr_o;
  logic [AW-1:0]     s_paddr_o;
  logic [DW-1:0]     s_pwdata_o;
  logic              s_pwrite_o;
  logic              s_psel_o;
  logic              s_penable_o;
  logic [DW-1:0]     s_prdata_i = '0;
  logic              s_pready_i = 1'b0;
  logic              s_pslverr_i = 1'b0;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  apb_rr_arbiter #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .NUM_MASTERS(NM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .m_paddr_i(m_paddr_i),
    .m_pwdata_i(m_pwdata_i),
    .m_pwrite_i(m_pwrite_i),
    .m_psel_i(m_psel_i),
    .m_penable_i(m_penable_i),
    .m_prdata_o(m_prdata_o),
    .m_pready_o(m_pready_o),
    .m_pslverr_o(m_pslverr_o),
    .s_paddr_o(s_paddr_o),
    .s_pwdata_o(s_pwdata_o),
    .s_pwrite_o(s_pwrite_o),
    .s_psel_o(s_psel_o),
    .s_penable_o(s_penable_o),
    .s_prdata_i(s_prdata_i),
    .s_pready_i(s_pready_i),
    .s_pslverr_i(s_pslverr_i),
    .grant_o(grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int last_owner = NM - 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One arbitration round starting at a negedge with the FSM idle.
  // w = ACCESS cycle index in which the slave answers (>= TO: never).
  task automatic do_round(input logic [NM-1:0] mask,
                          input logic [NM*AW-1:0] a,
                          input logic [NM*DW-1:0] d,
                          input logic [NM-1:0] wr,
                          input int w,
                          input logic [DW-1:0] rd,
                          input logic err);
    int win;
    int last;
    bit timed;
    logic [NM*DW-1:0] exp_rd;
    m_psel_i    = mask;
    m_penable_i = mask;
    m_paddr_i   = a;
    m_pwdata_i  = d;
    m_pwrite_i  = wr;
    s_pready_i  = 1'($urandom % 2);
    win = -1;
    for (int k = 1; k <= NM; k++)
      if (win < 0 && mask[(last_owner + k) % NM])
        win = (last_owner + k) % NM;
    @(negedge clk_i);
    if (win < 0) begin
      chk("idle_grant", 64'(grant_o), 64'd0);
      chk("idle_psel", 64'(s_psel_o), 64'd0);
      chk("idle_ready", 64'(m_pready_o), 64'd0);
      return;
    end
    last_owner = win;
    chk("setup_grant", 64'(grant_o), 64'd1 << win);
    chk("setup_sel", 64'({s_psel_o, s_penable_o}), 64'b10);
    chk("setup_addr", 64'(s_paddr_o), 64'(a[win*AW +: AW]));
    chk("setup_wdata", 64'(s_pwdata_o), 64'(d[win*DW +: DW]));
    chk("setup_write", 64'(s_pwrite_o), 64'(wr[win]));
    chk("setup_ready", 64'(m_pready_o), 64'd0);
    timed = (w >= TO);
    last  = timed ? TO - 1 : w;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk_i);
      s_pready_i  = (j == w);
      s_prdata_i  = (j == w) ? rd : DW'($urandom);
      s_pslverr_i = err;
      #1;
      chk("acc_sel", 64'({s_psel_o, s_penable_o}), 64'b11);
      chk("acc_addr", 64'(s_paddr_o), 64'(a[win*AW +: AW]));
      chk("acc_wdata", 64'(s_pwdata_o), 64'(d[win*DW +: DW]));
      chk("acc_ready", 64'(m_pready_o),
          (j == last) ? (64'd1 << win) : 64'd0);
      chk("acc_tmo", 64'(timeout_o), 64'(timed && j == last));
      if (j == last) begin
        exp_rd = '0;
        exp_rd[win*DW +: DW] = timed ? '0 : rd;
        chk("rsp_err", 64'(m_pslverr_o),
            (timed || err) ? (64'd1 << win) : 64'd0);
        chk("rsp_data", 64'(m_prdata_o), 64'(exp_rd));
      end
    end
    @(negedge clk_i);
    s_pready_i = 1'($urandom % 2);
    #1;
    chk("post_grant", 64'(grant_o), 64'd0);
    chk("post_sel", 64'({s_psel_o, s_penable_o}), 64'b00);
    chk("post_ready", 64'(m_pready_o), 64'd0);
    chk("post_tmo", 64'(timeout_o), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_sel", 64'({s_psel_o, s_penable_o}), 64'b00);
    chk("rst_addr", 64'(s_paddr_o), 64'd0);
    chk("rst_ready", 64'(m_pready_o), 64'd0);
    chk("rst_tmo", 64'(timeout_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_round(2'b11, {32'h2000_0004, 32'h2000_0000},
             {32'h22, 32'h11}, 2'b11, 0, 32'h0, 1'b0);
    do_round(2'b11, {32'h2000_0004, 32'h2000_0000},
             {32'h22, 32'h11}, 2'b11, 0, 32'h0, 1'b0);
    do_round(2'b01, {32'h0, 32'h1A10_0008}, '0, 2'b00,
             0, 32'hDEAD_BEEF, 1'b0);
    for (int n = 0; n < 6; n++)
      do_round(2'b11, {32'h3000_0100, 32'h3000_0000},
               {32'hB0 + n, 32'hA0 + n}, 2'b00, 0, 32'h600D + n, 1'b0);
    do_round(2'b01, {32'h0, 32'h4000_0010}, {32'h0, 32'h5A5A},
             2'b01, 3, 32'h1234, 1'b1);
    do_round(2'b10, {32'h5000_0020, 32'h0}, '0, 2'b00,
             50, 32'hFFFF, 1'b0);
    do_round(2'b01, {32'h0, 32'h5000_0040}, '0, 2'b00,
             1, 32'h7777, 1'b0);
    do_round(2'b01, {32'h0, 32'h5000_0044}, '0, 2'b00,
             7, 32'h8888, 1'b1);

    for (int n = 0; n < 150; n++)
      do_round(NM'($urandom % 4),
               {32'($urandom), 32'($urandom)},
               {32'($urandom), 32'($urandom)},
               NM'($urandom % 4), int'($urandom % 12),
               32'($urandom), 1'($urandom % 2));

    m_psel_i   = 2'b10;
    m_paddr_i  = {32'h6000_0000, 32'h0};
    s_pready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_grant", 64'(grant_o), 64'b10);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_sel", 64'({s_psel_o, s_penable_o}), 64'b00);
    chk("arst_grant", 64'(grant_o), 64'd0);
    chk("arst_ready", 64'(m_pready_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_owner = NM - 1;
    do_round(2'b11, {32'h7000_0004, 32'h7000_0000},
             {32'h2, 32'h1}, 2'b00, 0, 32'hC0DE, 1'b0);
    do_round(2'b11, {32'h7000_0004, 32'h7000_0000},
             {32'h2, 32'h1}, 2'b00, 2, 32'hC0DF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
